// File: rtl/seq_det_ctrl.sv
// Run controller for a programmable serial pattern detector: latches a pattern
// at start, counts matches on a valid-qualified bit stream, stops at a target count.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               in,
    input  logic               in_valid,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_count;
    logic               r_match;
    logic               r_cfg_err;
    logic               r_busy;
    logic               r_done;

    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_hit;
    logic               w_cfg_bad;
    logic [CNT_W-1:0]   w_count_inc;

    // Next history/fill and the hit decision for the bit being sampled this cycle.
    always_comb begin
        w_mask      = {MAX_LEN{1'b0}};
        w_hist_nxt  = {r_hist[MAX_LEN-2:0], in};
        w_fill_nxt  = (r_fill >= LEN_W'(MAX_LEN)) ? r_fill : r_fill + {{(LEN_W-1){1'b0}}, 1'b1};
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
        w_hit       = in_valid && (w_fill_nxt >= r_len) &&
                      (((w_hist_nxt ^ r_pat) & w_mask) == {MAX_LEN{1'b0}});
        w_cfg_bad   = (cfg_len == {LEN_W{1'b0}}) || (cfg_len > LEN_W'(MAX_LEN)) ||
                      (cfg_target == {CNT_W{1'b0}});
        w_count_inc = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Run-control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_hist    <= {MAX_LEN{1'b0}};
            r_fill    <= {LEN_W{1'b0}};
            r_pat     <= {MAX_LEN{1'b0}};
            r_len     <= {LEN_W{1'b0}};
            r_ovl     <= 1'b0;
            r_target  <= {CNT_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_match   <= 1'b0;
            r_cfg_err <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_match   <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    // abort always suppresses a coincident start
                    if (abort) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end else if (start) begin
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                            r_state   <= IDLE;
                            r_done    <= 1'b0;
                        end else begin
                            r_pat    <= cfg_pattern;
                            r_len    <= cfg_len;
                            r_ovl    <= cfg_overlap;
                            r_target <= cfg_target;
                            r_hist   <= {MAX_LEN{1'b0}};
                            r_fill   <= {LEN_W{1'b0}};
                            r_count  <= {CNT_W{1'b0}};
                            r_state  <= RUN;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (in_valid) begin
                        r_hist <= w_hist_nxt;
                        if (w_hit) begin
                            r_match <= 1'b1;
                            r_count <= w_count_inc;
                            r_fill  <= r_ovl ? w_fill_nxt : {LEN_W{1'b0}};
                            if (w_count_inc == r_target) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= RUN;
                            end
                        end else begin
                            r_fill <= w_fill_nxt;
                        end
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign match       = r_match;
    assign cfg_err     = r_cfg_err;
    assign match_count = r_count;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios and random traffic, all checked
// against a queue-based model of the match rules.
module tb_seq_det_ctrl;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic [CNT_W-1:0]   cfg_target = '0;
    logic               start = 1'b0, abort = 1'b0, in = 1'b0, in_valid = 1'b0;
    logic               busy, match, done, cfg_err;
    logic [CNT_W-1:0]   match_count;

    int total = 0;
    int bad   = 0;

    // reference model: received bits since the last fill reset, newest at the back
    bit m_run, m_done, m_match, m_err, m_ovl;
    int m_count, m_len, m_tgt;
    bit [MAX_LEN-1:0] m_pat;
    bit q[$];

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start),
        .abort(abort), .in(in), .in_valid(in_valid), .busy(busy), .match(match),
        .match_count(match_count), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_match = 0; m_err = 0; m_count = 0;
        m_len = 0; m_tgt = 0; m_ovl = 0; m_pat = '0;
        q.delete();
    endtask

    function automatic bit tail_matches();
        if (q.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (q[q.size() - 1 - k] != m_pat[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_cycle();
        m_match = 0; m_err = 0;
        if (m_run) begin
            if (abort) m_run = 0;
            else if (in_valid) begin
                q.push_back(in);
                if (q.size() > MAX_LEN) void'(q.pop_front());
                if (tail_matches()) begin
                    m_match = 1; m_count++;
                    if (!m_ovl) q.delete();
                    if (m_count == m_tgt) begin m_run = 0; m_done = 1; end
                end
            end
        end else if (abort) begin
            m_done = 0;
        end else if (start) begin
            m_done = 0;
            if (cfg_len == 0 || cfg_len > MAX_LEN || cfg_target == 0) m_err = 1;
            else begin
                m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap;
                m_tgt = cfg_target; m_count = 0; m_run = 1; q.delete();
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"},  busy,        m_run);
        chk({tag, ".done"},  done,        m_done);
        chk({tag, ".match"}, match,       m_match);
        chk({tag, ".err"},   cfg_err,     m_err);
        chk({tag, ".count"}, match_count, m_count);
    endtask

    task automatic step(input string tag, input bit v, input bit b, input bit s, input bit a);
        in_valid = v; in = b; start = s; abort = a;
        model_cycle();
        @(posedge clk); #1;
        check_all(tag);
        in_valid = 0; start = 0; abort = 0;
    endtask

    task automatic cfg(input int pat, input int len, input bit ovl, input int tgt);
        cfg_pattern = MAX_LEN'(pat); cfg_len = LEN_W'(len);
        cfg_overlap = ovl; cfg_target = CNT_W'(tgt);
    endtask

    bit s1011 [7] = '{1, 0, 1, 1, 0, 1, 1};

    initial begin
        model_reset();
        #2;
        check_all("por");
        @(negedge clk); rst_n = 1'b1;

        // overlapping 1011, target 3
        cfg(8'b1011, 4, 1, 3);
        step("start_a", 0, 0, 1, 0);
        chk("start_a.busy_const", busy, 1);
        for (int i = 0; i < 7; i++) begin
            step("ovl", 1, s1011[i], 0, 0);
            if (i == 3 || i == 6) chk("ovl.pulse_const", match, 1);
        end
        chk("ovl.count_const", match_count, 2);
        chk("ovl.busy_const", busy, 1);
        step("abort_a", 0, 0, 0, 1);
        chk("abort_a.count_kept", match_count, 2);

        // non-overlapping 1011
        cfg(8'b1011, 4, 0, 3);
        step("start_b", 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step("novl", 1, s1011[i], 0, 0);
        chk("novl.count_const", match_count, 1);
        step("abort_b", 0, 0, 0, 1);

        // pattern 11, alternate invalid cycles, target 3 then ignored input
        cfg(8'b11, 2, 1, 3);
        step("start_c", 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step("alt.v", 1, 1, 0, 0);
            step("alt.nv", 0, 1, 0, 0);
        end
        chk("alt.done_const", done, 1);
        chk("alt.count_const", match_count, 3);
        for (int i = 0; i < 4; i++) step("alt.ign", 1, 1, 0, 0);
        chk("alt.hold_const", match_count, 3);

        // rejected configurations
        cfg(8'b1, 0, 0, 1);           step("err_len0", 0, 0, 1, 0);
        chk("err_len0.pulse_const", cfg_err, 1);
        cfg(8'b1, MAX_LEN + 1, 0, 1); step("err_lenbig", 0, 0, 1, 0);
        cfg(8'b1, 1, 0, 0);           step("err_tgt0", 0, 0, 1, 0);
        step("err_idle", 1, 1, 0, 0);
        chk("err_idle.busy_const", busy, 0);

        // abort + start collide with the completing hit
        cfg(8'b11, 2, 1, 2);
        step("start_d", 0, 0, 1, 0);
        step("coll", 1, 1, 0, 0);
        step("coll", 1, 1, 0, 0);
        cfg(8'b1, 1, 1, 5);
        step("coll.hit", 1, 1, 1, 1);
        chk("coll.match_const", match, 0);
        chk("coll.count_const", match_count, 1);
        chk("coll.done_const", done, 0);

        // async reset mid-run with three bits filled
        cfg(8'b1111, 4, 1, 9);
        step("start_e", 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 1, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("rst_mid");
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step("post_rst", 1, 1, 0, 0);

        // random traffic, config also scrambled during runs
        for (int n = 0; n < 3000; n++) begin
            cfg_pattern = MAX_LEN'($urandom);
            cfg_len     = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(0, MAX_LEN + 1))
                                                      : LEN_W'($urandom_range(1, 4));
            cfg_overlap = 1'($urandom);
            cfg_target  = CNT_W'($urandom_range(0, 4));
            step("rnd", $urandom_range(0, 9) < 7, 1'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
